nand_lun_arbiter: RTL and testbench
===================================

Name: nand_lun_arbiter

Overview:
Arbitrates one shared NAND channel bus (DQ/CLE/ALE/WE#/RE#) among NREQ command requesters. Each requester targets one CE# target of up to 2 LUNs. Tracks per-target ready/busy from the R/B# pins and blocks grants that would break the multi-LUN rules:
- no multi-LUN command while a Reset/ID/Config is busy;
- no 70h status while multiple LUN ops are outstanding.

It sits between the channel command sequencer and the package pins.

Parameters:
NREQ, 4, number of requesters (2..8)
NTGT, 4, number of CE# targets / R/B# inputs
TGT_W, 2, target id width, clog2(NTGT)
TWB_CYC, 8, R/B# blanking cycles after a busy-causing command (covers tWB)
TO_CYC, 2000000, busy watchdog limit in cycles (optional feature only)

Ports:
clk  in  1  channel clock
rst_n  in  1  asynchronous active-low reset
req_vld  in  NREQ  per-requester request, held until granted
req_tgt  in  NREQ*TGT_W  target id per requester
req_cls  in  NREQ*2  class per requester: 0=array op (00/30,80/10,60/D0 family), 1=exclusive (FFh/90h/ECh/EFh/EEh), 2=status 70h, 3=status 78h / data-out
req_last  in  NREQ  owner releases bus (1-cycle pulse)
cmd_issued  in  1  pulse from bus driver: owner's busy-causing confirm cycle latched on pins
rb_n  in  NTGT  raw R/B# per target, asynchronous
gnt  out  NREQ  one-hot grant
own_vld  out  1  bus owned
own_idx  out  3  index of owner
tgt_rdy  out  NTGT  target ready (synced R/B# high and no blanking)
err_proto  out  1  sticky: req_last from non-owner, or cmd_issued with no owner
err_timeout  out  NTGT  sticky per-target watchdog flag

Behaviour:
- Reset: gnt=0, own_vld=0, own_idx=0, tgt_rdy=0 until sync chain fills, err_*=0, RR pointer=0, all target state cleared. Reset mid-ownership drops the grant immediately (async).
- rb_n: 2-flop synchronizer per target. tgt_rdy[t] = rb_sync[t] & (blank_cnt[t]==0).
- Per-target state:
  - blank_cnt, 0..TWB_CYC.
  - excl flag.
  - ops_cnt, 2 bits, saturating at 2.
  - On cmd_issued: with owner target t, blank_cnt[t]=TWB_CYC. Class 1 sets excl[t]; class 0 increments ops_cnt[t].
  - While tgt_rdy[t]=1 and no cmd_issued this cycle: excl[t]=0, ops_cnt[t]=0.
  - cmd_issued and ready in the same cycle: the issue wins.
- Eligibility of requester i with target t:
  - Class 0/3: excl[t]==0.
  - Class 1: tgt_rdy[t] & ops_cnt[t]==0 & excl[t]==0.
  - Class 2: excl[t]==0 & ops_cnt[t]<=1.
- FSM:
  - IDLE: any eligible req_vld → ARB.
  - ARB: pick the first eligible requester at or after rr_ptr (wrapping), register gnt → OWN. Grant latency is 2 cycles from req_vld in IDLE.
  - OWN: hold gnt until req_last of owner, or owner drops req_vld → REL. rr_ptr = owner+1 mod NREQ.
  - REL: one cycle with gnt=0 (bus turnaround) → IDLE.
- Ineligible requests wait; there is no starvation bypass. Fairness within eligible requesters is round-robin.
- req_last from a non-owner is ignored and sets err_proto. cmd_issued in IDLE/ARB/REL is ignored and sets err_proto.
- Requester with req_tgt ≥ NTGT is never eligible.

Optional Feature:
NAND_ARB_TIMEOUT_EN.
- Defined: per-target counter increments while tgt_rdy[t]=0 and clears when ready.
  - On reaching TO_CYC: err_timeout[t]=1 (sticky until reset), excl[t]/ops_cnt[t] are forced clear, and blanking is forced to 0. The target is then treated as ready regardless of rb_sync so the channel cannot deadlock.
- Undefined: no counters; err_timeout tied 0.

Test Plan:
- Req0 and req2 assert in the same cycle, both class 0, rr_ptr=0 → gnt=0001 two cycles later. After req_last: one REL cycle, then gnt=0100.
- Owner tgt0 pulses cmd_issued with class 1, rb_n[0] held high → tgt_rdy[0]=0 for TWB_CYC cycles. A class-0 req to tgt0 is not granted until rb_n[0] goes low then high and tgt_rdy[0]=1.
- Two class-0 cmd_issued to tgt1 (ops_cnt=2), rb_n[1] low → class-2 req to tgt1 blocked, class-3 req to tgt1 granted. After rb_n[1] high, class-2 is granted.
- Class-1 req to tgt2 while ops_cnt[2]=1 → held; a class-0 req to tgt3 on another requester is granted meanwhile.
- Assert rst_n=0 during OWN → gnt=0 and own_vld=0 immediately. After release, a request is granted 2 cycles after rst_n deassert plus sync-fill.
- NAND_ARB_TIMEOUT_EN with TO_CYC=100, rb_n[0] stuck low → err_timeout[0]=1 at cycle 100. A pending class-1 req to tgt0 is then granted, and err_proto stays 0.

Source files
------------

// File: rtl/nand_lun_arbiter.sv
// Shared NAND channel bus arbiter with per-target R/B# tracking and multi-LUN grant rules.
// Optional busy watchdog enabled by defining NAND_ARB_TIMEOUT_EN.
module nand_lun_arbiter #(
  parameter int NREQ    = 4,
  parameter int NTGT    = 4,
  parameter int TGT_W   = 2,
  parameter int TWB_CYC = 8,
  parameter int TO_CYC  = 2000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_vld,
  input  logic [NREQ*TGT_W-1:0] req_tgt,
  input  logic [NREQ*2-1:0]     req_cls,
  input  logic [NREQ-1:0]       req_last,
  input  logic                  cmd_issued,
  input  logic [NTGT-1:0]       rb_n,
  output logic [NREQ-1:0]       gnt,
  output logic                  own_vld,
  output logic [2:0]            own_idx,
  output logic [NTGT-1:0]       tgt_rdy,
  output logic                  err_proto,
  output logic [NTGT-1:0]       err_timeout
);

  localparam int BW = $clog2(TWB_CYC + 1);
  localparam int unsigned NREQ_U = NREQ;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_OWN, S_REL} state_t;

  state_t           state;
  logic [2:0]       rr_ptr;
  logic [TGT_W-1:0] own_tgt;
  logic [1:0]       own_cls;

  logic [NTGT-1:0]  rb_meta;
  logic [NTGT-1:0]  rb_sync;
  logic [BW-1:0]    blank_cnt [NTGT];
  logic [NTGT-1:0]  excl;
  logic [1:0]       ops_cnt [NTGT];
  logic [NTGT-1:0]  to_hit;
  logic [NTGT-1:0]  to_flag;

  logic [NREQ-1:0]  elig;
  logic             found;
  logic [2:0]       pick;
  logic             issue_ok;
  logic             proto_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_meta <= '0;
      rb_sync <= '0;
    end else begin
      rb_meta <= rb_n;
      rb_sync <= rb_meta;
    end
  end

  // A timed-out target is treated as ready so the channel cannot deadlock.
  always_comb begin
    tgt_rdy = '0;
    for (int unsigned t = 0; t < NTGT; t++)
      tgt_rdy[t] = (rb_sync[t] | to_flag[t]) & (blank_cnt[t] == '0);
  end

  assign issue_ok = cmd_issued && (state == S_OWN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned t = 0; t < NTGT; t++) begin
        blank_cnt[t] <= '0;
        ops_cnt[t]   <= '0;
      end
      excl <= '0;
    end else begin
      for (int unsigned t = 0; t < NTGT; t++) begin
        if (to_hit[t]) begin
          blank_cnt[t] <= '0;
          excl[t]      <= 1'b0;
          ops_cnt[t]   <= '0;
        end else if (issue_ok && (32'(own_tgt) == t)) begin
          blank_cnt[t] <= BW'(TWB_CYC);
          if (own_cls == 2'd1)
            excl[t] <= 1'b1;
          else if (own_cls == 2'd0 && ops_cnt[t] != 2'd2)
            ops_cnt[t] <= ops_cnt[t] + 2'd1;
        end else begin
          if (blank_cnt[t] != '0)
            blank_cnt[t] <= blank_cnt[t] - BW'(1);
          if (tgt_rdy[t]) begin
            excl[t]    <= 1'b0;
            ops_cnt[t] <= '0;
          end
        end
      end
    end
  end

`ifdef NAND_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] to_cnt [NTGT];

  always_comb begin
    to_hit = '0;
    for (int unsigned t = 0; t < NTGT; t++)
      to_hit[t] = !tgt_rdy[t] && (to_cnt[t] == TW'(TO_CYC - 1));
  end

  assign to_flag = err_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned t = 0; t < NTGT; t++)
        to_cnt[t] <= '0;
      err_timeout <= '0;
    end else begin
      for (int unsigned t = 0; t < NTGT; t++) begin
        if (tgt_rdy[t])
          to_cnt[t] <= '0;
        else if (to_cnt[t] != TW'(TO_CYC))
          to_cnt[t] <= to_cnt[t] + TW'(1);
        if (to_hit[t])
          err_timeout[t] <= 1'b1;
      end
    end
  end
`else
  assign to_hit      = '0;
  assign to_flag     = '0;
  assign err_timeout = '0;
`endif

  always_comb begin
    logic [TGT_W-1:0] tg;
    logic [1:0]       cl;
    elig = '0;
    tg   = '0;
    cl   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      tg = req_tgt[i*TGT_W +: TGT_W];
      cl = req_cls[i*2 +: 2];
      if (req_vld[i] && (32'(tg) < NTGT)) begin
        case (cl)
          2'd1:    elig[i] = tgt_rdy[tg] && (ops_cnt[tg] == 2'd0) && !excl[tg];
          2'd2:    elig[i] = !excl[tg] && (ops_cnt[tg] <= 2'd1);
          default: elig[i] = !excl[tg];
        endcase
      end
    end
  end

  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      idx = (32'(rr_ptr) + k) % NREQ_U;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = 3'(idx);
      end
    end
  end

  // Outside OWN every req_last is stray; inside OWN only the owner may pulse it.
  assign proto_bad = (cmd_issued && (state != S_OWN)) ||
                     (|(req_last & ((state == S_OWN) ? ~gnt : '1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gnt       <= '0;
      own_vld   <= 1'b0;
      own_idx   <= '0;
      rr_ptr    <= '0;
      own_tgt   <= '0;
      own_cls   <= '0;
      err_proto <= 1'b0;
    end else begin
      if (proto_bad)
        err_proto <= 1'b1;
      case (state)
        S_IDLE: if (|elig) state <= S_ARB;
        S_ARB: begin
          if (found) begin
            gnt     <= NREQ'(1) << pick;
            own_vld <= 1'b1;
            own_idx <= pick;
            own_tgt <= req_tgt[32'(pick)*TGT_W +: TGT_W];
            own_cls <= req_cls[32'(pick)*2 +: 2];
            state   <= S_OWN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_OWN: begin
          if (req_last[own_idx] || !req_vld[own_idx]) begin
            gnt     <= '0;
            own_vld <= 1'b0;
            rr_ptr  <= (own_idx == 3'(NREQ - 1)) ? 3'd0 : own_idx + 3'd1;
            state   <= S_REL;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_lun_arbiter.sv
// Directed self-checking bench for nand_lun_arbiter (default parameters, TO_CYC=100).
module tb_nand_lun_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_vld;
  logic [7:0] req_tgt;
  logic [7:0] req_cls;
  logic [3:0] req_last;
  logic       cmd_issued;
  logic [3:0] rb_n;
  logic [3:0] gnt;
  logic       own_vld;
  logic [2:0] own_idx;
  logic [3:0] tgt_rdy;
  logic       err_proto;
  logic [3:0] err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  nand_lun_arbiter #(.NREQ(4), .NTGT(4), .TGT_W(2), .TWB_CYC(8), .TO_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_tgt(req_tgt), .req_cls(req_cls),
    .req_last(req_last), .cmd_issued(cmd_issued), .rb_n(rb_n), .gnt(gnt),
    .own_vld(own_vld), .own_idx(own_idx), .tgt_rdy(tgt_rdy), .err_proto(err_proto),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input int tgt, input int cls);
    req_vld[i]         = v;
    req_tgt[i*2 +: 2]  = 2'(tgt);
    req_cls[i*2 +: 2]  = 2'(cls);
  endtask

  task automatic release_owner(input int i);
    req_last[i] = 1'b1;
    req_vld[i]  = 1'b0;
    tick();
    req_last[i] = 1'b0;
  endtask

  task automatic issue();
    cmd_issued = 1'b1;
    tick();
    cmd_issued = 1'b0;
  endtask

  task automatic wait_gnt(input string tag, input logic [3:0] exp, input int max);
    for (int k = 0; k < max; k++) begin
      if (gnt != '0) break;
      tick();
    end
    chk(tag, {28'd0, gnt}, {28'd0, exp});
  endtask

  task automatic idle_for(input string tag, input int n);
    logic [3:0] seen;
    seen = '0;
    for (int k = 0; k < n; k++) begin
      tick();
      seen = seen | gnt;
    end
    chk(tag, {28'd0, seen}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_vld = '0; req_tgt = '0; req_cls = '0; req_last = '0;
    cmd_issued = 1'b0; rb_n = '1;
    #1;
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_own_vld", {31'd0, own_vld}, 32'd0);
    chk("rst_own_idx", {29'd0, own_idx}, 32'd0);
    chk("rst_tgt_rdy", {28'd0, tgt_rdy}, 32'd0);
    chk("rst_err_proto", {31'd0, err_proto}, 32'd0);
    chk("rst_err_timeout", {28'd0, err_timeout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("sync_not_full", {28'd0, tgt_rdy}, 32'd0);
    tick();
    chk("sync_full", {28'd0, tgt_rdy}, 32'hF);

    // Round-robin from pointer 0, two-cycle grant latency, turnaround
    set_req(0, 1, 0, 0);
    set_req(2, 1, 3, 0);
    tick();
    chk("rr_arb_no_gnt", {28'd0, gnt}, 32'd0);
    tick();
    chk("rr_gnt0", {28'd0, gnt}, 32'h1);
    chk("rr_own_idx0", {29'd0, own_idx}, 32'd0);
    chk("rr_own_vld", {31'd0, own_vld}, 32'd1);
    release_owner(0);
    chk("rel_gnt0", {28'd0, gnt}, 32'd0);
    chk("rel_own_vld", {31'd0, own_vld}, 32'd0);
    wait_gnt("rr_gnt2", 4'b0100, 5);
    chk("rr_own_idx2", {29'd0, own_idx}, 32'd2);
    release_owner(2);

    // Exclusive command on tgt0: blanking then busy blocks class 0
    set_req(1, 1, 0, 1);
    wait_gnt("excl_gnt1", 4'b0010, 6);
    issue();
    chk("blank_start", {31'd0, tgt_rdy[0]}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("blank_hold", {31'd0, tgt_rdy[0]}, 32'd0);
    end
    rb_n[0] = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("busy_rdy0", {31'd0, tgt_rdy[0]}, 32'd0);
    release_owner(1);
    set_req(3, 1, 0, 0);
    idle_for("excl_block", 12);
    rb_n[0] = 1'b1;
    wait_gnt("excl_clear_gnt3", 4'b1000, 10);
    chk("excl_rdy0", {31'd0, tgt_rdy[0]}, 32'd1);
    release_owner(3);

    // Two outstanding LUN ops on tgt1: 70h blocked, 78h allowed
    rb_n[1] = 1'b0;
    set_req(0, 1, 1, 0);
    wait_gnt("ops_gnt0", 4'b0001, 6);
    issue();
    tick();
    issue();
    release_owner(0);
    set_req(1, 1, 1, 2);
    set_req(2, 1, 1, 3);
    wait_gnt("st78_gnt2", 4'b0100, 6);
    release_owner(2);
    idle_for("st70_block", 10);
    rb_n[1] = 1'b1;
    wait_gnt("st70_gnt1", 4'b0010, 10);
    release_owner(1);

    // Class 1 waits on outstanding op; other target proceeds
    rb_n[2] = 1'b0;
    set_req(0, 1, 2, 0);
    wait_gnt("op2_gnt0", 4'b0001, 6);
    issue();
    release_owner(0);
    set_req(1, 1, 2, 1);
    set_req(3, 1, 3, 0);
    wait_gnt("bypass_gnt3", 4'b1000, 6);
    release_owner(3);
    idle_for("excl_wait_ops", 8);
    rb_n[2] = 1'b1;
    wait_gnt("excl_gnt_after", 4'b0010, 10);
    release_owner(1);
    chk("no_proto_err", {31'd0, err_proto}, 32'd0);

    tick();
    tick();
    issue();
    chk("proto_issue_idle", {31'd0, err_proto}, 32'd1);

    // Asynchronous reset during ownership
    set_req(0, 1, 0, 1);
    wait_gnt("pre_rst_gnt", 4'b0001, 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", {28'd0, gnt}, 32'd0);
    chk("async_rst_own", {31'd0, own_vld}, 32'd0);
    chk("async_rst_proto", {31'd0, err_proto}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("post_rst_early", {28'd0, gnt}, 32'd0);
    tick();
    chk("post_rst_gnt", {28'd0, gnt}, 32'h1);
    req_last[3] = 1'b1;
    tick();
    req_last[3] = 1'b0;
    chk("proto_nonowner_last", {31'd0, err_proto}, 32'd1);
    chk("nonowner_last_keeps_gnt", {28'd0, gnt}, 32'h1);
    release_owner(0);

`ifdef NAND_ARB_TIMEOUT_EN
    begin
      int cyc;
      rst_n = 1'b0;
      rb_n  = 4'b1110;
      #3;
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      while (!err_timeout[0] && cyc < 300) begin
        tick();
        cyc++;
      end
      chk("to_cycle", cyc, 32'd100);
      chk("to_flag0", {31'd0, err_timeout[0]}, 32'd1);
      chk("to_others", {29'd0, err_timeout[3:1]}, 32'd0);
      set_req(1, 1, 0, 1);
      wait_gnt("to_excl_gnt", 4'b0010, 8);
      chk("to_no_proto", {31'd0, err_proto}, 32'd0);
      release_owner(1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
